// File: rtl/l1_i_ctrl_nway.sv
// -----------------------------------------------------------------------------
// l1_i_ctrl_nway
// N-way set-associative L1 instruction-cache tag/control block. Owns the tag,
// valid and LRU-age arrays, sequences hit/miss/allocate/refill, walks every set
// on flush, and tells the separate L1 I data array which way to read/refill.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tag_C_L1          fetch tag            (TNUM)
//   index_C_L1        fetch set index      (INUM)
//   read_C_L1         fetch request
//   flush             invalidate whole cache (wins over read_C_L1)
//   ready_L2_L1       L2 line available
//   stall             core must hold (FSM not idle)
//   read_L1_L2        line request to L2 (ALLOCATE)
//   tag_L1_L2         upper TNUM2 bits of the latched tag
//   index_L1_L2       {low latched tag bits, latched index}
//   refill            data array writes the L2 line into 'way'
//   way               registered hit or victim way
//   hit_o / miss_o    one-cycle lookup result pulses
//   hit_cnt_o,
//   miss_cnt_o        saturating 32-bit event counters (only with
//                     L1I_PERF_CNT_EN defined)
//
// Optional feature macro: L1I_PERF_CNT_EN
// -----------------------------------------------------------------------------
module l1_i_ctrl_nway #(
    parameter int TNUM  = 21,
    parameter int INUM  = 26 - TNUM,
    parameter int TNUM2 = 18,
    parameter int INUM2 = 26 - TNUM2,
    parameter int WAY   = 4,
    parameter int WW    = $clog2(WAY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TNUM-1:0]  tag_C_L1,
    input  logic [INUM-1:0]  index_C_L1,
    input  logic             read_C_L1,
    input  logic             flush,
    input  logic             ready_L2_L1,
    output logic             stall,
    output logic             read_L1_L2,
    output logic [TNUM2-1:0] tag_L1_L2,
    output logic [INUM2-1:0] index_L1_L2,
    output logic             refill,
    output logic [WW-1:0]    way,
    output logic             hit_o,
    output logic             miss_o
`ifdef L1I_PERF_CNT_EN
    ,
    output logic [31:0]      hit_cnt_o,
    output logic [31:0]      miss_cnt_o
`endif
);

    localparam int SETS = 1 << INUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_ALLOCATE,
        S_REFILL,
        S_FLUSH
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [TNUM-1:0] r_tag   [SETS][WAY];
    logic [WAY-1:0]  r_valid [SETS];
    logic [WW-1:0]   r_age   [SETS][WAY];

    logic [TNUM-1:0] r_req_tag;
    logic [INUM-1:0] r_req_idx;
    logic [WW-1:0]   r_way;
    logic [INUM-1:0] r_fcnt;

    logic            w_hit;
    logic [WW-1:0]   w_hit_way;
    logic            w_inv_found;
    logic [WW-1:0]   w_victim;
    logic            w_touch_en;
    logic [WW-1:0]   w_touch_way;
    logic [WW-1:0]   w_touch_age;

    // Tag compare across all ways of the latched set
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int unsigned i = 0; i < WAY; i++) begin
            if (r_valid[r_req_idx][i] && (r_tag[r_req_idx][i] == r_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(i);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the oldest (age WAY-1)
    always_comb begin
        w_victim    = '0;
        w_inv_found = 1'b0;
        for (int unsigned i = 0; i < WAY; i++) begin
            if (!w_inv_found && !r_valid[r_req_idx][i]) begin
                w_victim    = WW'(i);
                w_inv_found = 1'b1;
            end
        end
        if (!w_inv_found) begin
            for (int unsigned i = 0; i < WAY; i++) begin
                if (r_age[r_req_idx][i] == WW'(WAY - 1)) begin
                    w_victim = WW'(i);
                end
            end
        end
    end

    // LRU touch on a hit in COMPARE or on the refilled way in REFILL
    always_comb begin
        w_touch_en  = ((r_state == S_COMPARE) && w_hit) || (r_state == S_REFILL);
        w_touch_way = (r_state == S_REFILL) ? r_way : w_hit_way;
        w_touch_age = r_age[r_req_idx][w_touch_way];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        stall      = (r_state != S_IDLE);
        read_L1_L2 = 1'b0;
        refill     = 1'b0;
        hit_o      = 1'b0;
        miss_o     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next = S_FLUSH;
                end else if (read_C_L1) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    hit_o  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    miss_o = 1'b1;
                    w_next = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                read_L1_L2 = 1'b1;
                if (ready_L2_L1) begin
                    w_next = S_REFILL;
                end
            end
            S_REFILL: begin
                refill = 1'b1;
                w_next = S_COMPARE;
            end
            S_FLUSH: begin
                if (r_fcnt == '1) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Arrays, request latch, way register and flush walker
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                for (int unsigned w = 0; w < WAY; w++) begin
                    r_tag[s][w] <= '0;
                    r_age[s][w] <= WW'(w);
                end
            end
            r_req_tag <= '0;
            r_req_idx <= '0;
            r_way     <= '0;
            r_fcnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_fcnt <= '0;
                    end else if (read_C_L1) begin
                        r_req_tag <= tag_C_L1;
                        r_req_idx <= index_C_L1;
                    end
                end
                S_COMPARE: begin
                    r_way <= w_hit ? w_hit_way : w_victim;
                end
                S_ALLOCATE: begin
                    if (ready_L2_L1) begin
                        r_tag[r_req_idx][r_way]   <= r_req_tag;
                        r_valid[r_req_idx][r_way] <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_valid[r_fcnt] <= '0;
                    for (int unsigned w = 0; w < WAY; w++) begin
                        r_age[r_fcnt][w] <= WW'(w);
                    end
                    r_fcnt <= r_fcnt + 1'b1;
                end
                default: ;
            endcase

            // Ages younger than the touched way shift older by one; the
            // touched way becomes youngest, so ages stay a permutation.
            if (w_touch_en) begin
                for (int unsigned w = 0; w < WAY; w++) begin
                    if (WW'(w) == w_touch_way) begin
                        r_age[r_req_idx][w] <= '0;
                    end else if (r_age[r_req_idx][w] < w_touch_age) begin
                        r_age[r_req_idx][w] <= r_age[r_req_idx][w] + 1'b1;
                    end
                end
            end
        end
    end

    assign way         = r_way;
    assign tag_L1_L2   = r_req_tag[TNUM-1 -: TNUM2];
    assign index_L1_L2 = {r_req_tag[TNUM-TNUM2-1:0], r_req_idx};

`ifdef L1I_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (hit_o && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (miss_o && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_l1_i_ctrl_nway.sv
// -----------------------------------------------------------------------------
// tb_l1_i_ctrl_nway
// Self-checking bench for l1_i_ctrl_nway (WAY=4, INUM=5). A reference model
// keeps each set's ways as an MRU-first list; every read pushes the expected
// hit/miss events (kind and way) into a queue, which a monitor pops as the DUT
// pulses hit_o/miss_o. Per-request stall/read/refill cycle counts are checked
// directly.
// -----------------------------------------------------------------------------
module tb_l1_i_ctrl_nway;

    localparam int TNUM  = 21;
    localparam int INUM  = 5;
    localparam int TNUM2 = 18;
    localparam int INUM2 = 8;
    localparam int WAY   = 4;
    localparam int WW    = 2;
    localparam int SETS  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [TNUM-1:0]  tag_C_L1;
    logic [INUM-1:0]  index_C_L1;
    logic             read_C_L1;
    logic             flush;
    logic             ready_L2_L1;
    logic             stall;
    logic             read_L1_L2;
    logic [TNUM2-1:0] tag_L1_L2;
    logic [INUM2-1:0] index_L1_L2;
    logic             refill;
    logic [WW-1:0]    way;
    logic             hit_o;
    logic             miss_o;
`ifdef L1I_PERF_CNT_EN
    logic [31:0]      hit_cnt_o;
    logic [31:0]      miss_cnt_o;
`endif

    always #5 clk = ~clk;

    l1_i_ctrl_nway #(
        .TNUM (TNUM),
        .INUM (INUM),
        .TNUM2(TNUM2),
        .INUM2(INUM2),
        .WAY  (WAY),
        .WW   (WW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tag_C_L1   (tag_C_L1),
        .index_C_L1 (index_C_L1),
        .read_C_L1  (read_C_L1),
        .flush      (flush),
        .ready_L2_L1(ready_L2_L1),
        .stall      (stall),
        .read_L1_L2 (read_L1_L2),
        .tag_L1_L2  (tag_L1_L2),
        .index_L1_L2(index_L1_L2),
        .refill     (refill),
        .way        (way),
        .hit_o      (hit_o),
        .miss_o     (miss_o)
`ifdef L1I_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit is_hit;
        int way;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    bit  pend     = 1'b0;
    bit  pend_hit = 1'b0;

    // Pulse seen on one negedge; way is checked on the next, once registered
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_kind", 64'(pend_hit), 64'(mon_e.is_hit));
                check("ev_way", 64'(way), 64'(mon_e.way));
            end
        end
        if (hit_o || miss_o) begin
            pend     = 1'b1;
            pend_hit = hit_o;
        end
    end

    // Reference model: order[s][0] is MRU, order[s][WAY-1] is LRU
    int m_tag   [SETS][WAY];
    bit m_valid [SETS][WAY];
    int m_order [SETS][WAY];
    int m_hits  = 0;
    int m_miss  = 0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAY; w++) begin
                m_valid[s][w] = 1'b0;
                m_order[s][w] = w;
            end
        end
    endtask

    task automatic model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int j = 0; j < WAY; j++) if (m_order[s][j] == w) p = j;
        for (int j = p; j > 0; j--) m_order[s][j] = m_order[s][j-1];
        m_order[s][0] = w;
    endtask

    // Issue one read; called right after a posedge (+#1)
    task automatic do_read(input int tag, input int idx, input int delay, input string name);
        int  hw, v, n, sc, rc, fc, a;
        ev_t e;
        int  exp_stall, exp_rd;
        hw = -1;
        for (int w = 0; w < WAY; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) hw = w;
        if (hw >= 0) begin
            e.is_hit = 1'b1; e.way = hw; exp_q.push_back(e);
            model_touch(idx, hw);
            m_hits++;
            exp_stall = 1; exp_rd = 0;
        end else begin
            v = -1;
            for (int w = WAY - 1; w >= 0; w--) if (!m_valid[idx][w]) v = w;
            if (v < 0) v = m_order[idx][WAY-1];
            e.is_hit = 1'b0; e.way = v; exp_q.push_back(e);
            e.is_hit = 1'b1; e.way = v; exp_q.push_back(e);
            m_tag[idx][v] = tag; m_valid[idx][v] = 1'b1;
            model_touch(idx, v);
            m_miss++; m_hits++;
            exp_stall = delay + 3; exp_rd = delay;
        end

        tag_C_L1   = TNUM'(tag);
        index_C_L1 = INUM'(idx);
        read_C_L1  = 1'b1;
        @(posedge clk); #1;
        read_C_L1 = 1'b0;

        n = 0; sc = 0; rc = 0; fc = 0; a = 0;
        while (stall && n < 200) begin
            sc++;
            if (read_L1_L2) begin
                a++;
                rc++;
                if (a == 1) begin
                    check({name, "_tagL2"}, 64'(tag_L1_L2), 64'(tag >> 3));
                    check({name, "_idxL2"}, 64'(index_L1_L2), 64'(((tag & 7) << 5) | idx));
                end
            end
            if (refill) fc++;
            ready_L2_L1 = read_L1_L2 && (a >= delay);
            @(posedge clk); #1;
            n++;
        end
        ready_L2_L1 = 1'b0;
        check({name, "_timeout"}, 64'(n < 200), 64'd1);
        check({name, "_stall"}, 64'(sc), 64'(exp_stall));
        check({name, "_rd"}, 64'(rc), 64'(exp_rd));
        check({name, "_refill"}, 64'(fc), 64'(exp_rd > 0 ? 1 : 0));
    endtask

    task automatic do_flush_with_read(input int tag, input int idx);
        int n;
        flush      = 1'b1;
        read_C_L1  = 1'b1;
        tag_C_L1   = TNUM'(tag);
        index_C_L1 = INUM'(idx);
        @(posedge clk); #1;
        flush     = 1'b0;
        read_C_L1 = 1'b0;
        n = 0;
        while (stall && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("flush_cycles", 64'(n), 64'(SETS));
        model_reset();
    endtask

    task automatic reset_mid_allocate(input int tag, input int idx);
        int  v, n;
        ev_t e;
        v = -1;
        for (int w = WAY - 1; w >= 0; w--) if (!m_valid[idx][w]) v = w;
        if (v < 0) v = m_order[idx][WAY-1];
        e.is_hit = 1'b0; e.way = v; exp_q.push_back(e);
        tag_C_L1   = TNUM'(tag);
        index_C_L1 = INUM'(idx);
        read_C_L1  = 1'b1;
        @(posedge clk); #1;
        read_C_L1 = 1'b0;
        n = 0;
        while (!read_L1_L2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstmid_reach_alloc", 64'(read_L1_L2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_stall", 64'(stall), 64'd0);
        check("rstmid_rd", 64'(read_L1_L2), 64'd0);
        check("rstmid_refill", 64'(refill), 64'd0);
        check("rstmid_way", 64'(way), 64'd0);
        exp_q.delete();
        model_reset();
        m_hits = 0;
        m_miss = 0;
    endtask

    initial begin
        rst         = 1'b1;
        tag_C_L1    = '0;
        index_C_L1  = '0;
        read_C_L1   = 1'b0;
        flush       = 1'b0;
        ready_L2_L1 = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        check("rst_stall", 64'(stall), 64'd0);
        check("rst_rd", 64'(read_L1_L2), 64'd0);
        check("rst_refill", 64'(refill), 64'd0);
        check("rst_hit", 64'(hit_o), 64'd0);
        check("rst_miss", 64'(miss_o), 64'd0);
        check("rst_way", 64'(way), 64'd0);
        check("rst_tagL2", 64'(tag_L1_L2), 64'd0);
        check("rst_idxL2", 64'(index_L1_L2), 64'd0);

        // Cold miss
        do_read(32'h1ABCD, 3, 5, "cold");
        check("cold_way", 64'(way), 64'd0);

        // Fill remaining ways of set 3, then hit on the second tag
        do_read(32'h00011, 3, 1, "fill1");
        do_read(32'h00022, 3, 2, "fill2");
        do_read(32'h00033, 3, 1, "fill3");
        do_read(32'h00011, 3, 0, "fillhit");
        check("fillhit_way", 64'(way), 64'd1);

        // LRU eviction in set 5
        do_read(32'h00100, 5, 1, "lru_f0");
        do_read(32'h00200, 5, 3, "lru_f1");
        do_read(32'h00300, 5, 1, "lru_f2");
        do_read(32'h00400, 5, 2, "lru_f3");
        do_read(32'h00100, 5, 0, "lru_t0");
        do_read(32'h00300, 5, 0, "lru_t2");
        do_read(32'h00400, 5, 0, "lru_t3");
        do_read(32'h00500, 5, 1, "lru_new");
        check("evict_way", 64'(way), 64'd1);
        do_read(32'h00200, 5, 1, "lru_evicted");

        // Flush together with a read, then formerly resident tags miss
        do_flush_with_read(32'h00011, 3);
        do_read(32'h00011, 3, 1, "postflush_a");
        do_read(32'h00500, 5, 2, "postflush_b");
        do_read(32'h00011, 3, 0, "postflush_hit");

`ifdef L1I_PERF_CNT_EN
        check("perf_hits", 64'(hit_cnt_o), 64'(m_hits));
        check("perf_miss", 64'(miss_cnt_o), 64'(m_miss));
`endif

        // Reset while waiting for L2; cache must come back empty
        reset_mid_allocate(32'h0ABCD, 7);
        do_read(32'h1ABCD, 3, 1, "postrst");
        check("postrst_way", 64'(way), 64'd0);

`ifdef L1I_PERF_CNT_EN
        check("perf_hits_rst", 64'(hit_cnt_o), 64'(m_hits));
        check("perf_miss_rst", 64'(miss_cnt_o), 64'(m_miss));
`endif

        @(posedge clk); @(posedge clk); #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
